// File: rtl/rx_fct_credit_ctrl_pkg.sv
// Shared SpaceWire flow-control constants and the receive-credit FSM encoding.
// The TX credit counter uses the same credit constants.
package rx_fct_credit_ctrl_pkg;

    localparam int CREDIT_MAX = 56;
    localparam int FCT_CREDIT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } fct_state_e;

endpackage

// File: rtl/rx_fct_credit_ctrl_if.sv
// Bus between the RX credit manager, the receive FIFO/link FSM side, and the FCT encoder.
// Handshake: fct_req is held high until fct_ack pulses for one cycle; the FCT is committed on that edge.
interface rx_fct_credit_ctrl_if
    import rx_fct_credit_ctrl_pkg::*;
#(
    parameter int AWIDTH = 6
);

    logic              link_enable;
    logic [AWIDTH-1:0] fifo_count;
    logic              nchar_rx;
    logic              fct_ack;
    logic              fct_req;
    logic [AWIDTH-1:0] credit_out;
    logic              credit_error;
    fct_state_e        state;

    modport master (
        output link_enable, fifo_count, nchar_rx, fct_ack,
        input  fct_req, credit_out, credit_error, state
    );

    modport slave (
        input  link_enable, fifo_count, nchar_rx, fct_ack,
        output fct_req, credit_out, credit_error, state
    );

endinterface

// File: rtl/rx_fct_credit_ctrl.sv
// Receive-side flow-control credit manager: requests FCTs while the FIFO can absorb
// another 8 N-chars and flags any N-char that arrives when the peer holds no credit.
module rx_fct_credit_ctrl #(
    parameter int AWIDTH     = 6,
    parameter int FIFO_LAST  = 63,
    parameter int CREDIT_MAX = rx_fct_credit_ctrl_pkg::CREDIT_MAX,
    parameter int FCT_CREDIT = rx_fct_credit_ctrl_pkg::FCT_CREDIT
) (
    input  logic                 clock,
    input  logic                 reset,
    rx_fct_credit_ctrl_if.slave  bus
);

    import rx_fct_credit_ctrl_pkg::*;

    localparam int W1 = AWIDTH + 1;

    fct_state_e        r_state;
    logic              r_fct_req;
    logic [AWIDTH-1:0] r_credit;
    logic              r_error;

    fct_state_e        w_state_nxt;
    logic              w_req_nxt;
    logic [AWIDTH-1:0] w_credit_nxt;
    logic              w_error_nxt;

    logic [W1-1:0]     w_free;
    logic [W1-1:0]     w_cred_plus;
    logic              w_grant_ok;
    logic              w_ack_hit;

    // Extra bit keeps the free-space and credit sums from wrapping.
    assign w_free      = W1'(FIFO_LAST) - {1'b0, bus.fifo_count};
    assign w_cred_plus = {1'b0, r_credit} + W1'(FCT_CREDIT);
    assign w_grant_ok  = (w_cred_plus <= W1'(CREDIT_MAX)) && (w_cred_plus <= w_free);
    assign w_ack_hit   = (r_state == REQ) && bus.fct_ack;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_fct_req <= 1'b0;
            r_credit  <= '0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_fct_req <= w_req_nxt;
            r_credit  <= w_credit_nxt;
            r_error   <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = r_fct_req;
        w_credit_nxt = r_credit;
        w_error_nxt  = r_error;

        if (!bus.link_enable) begin
            // Link down abandons any pending request and forgets all credit.
            w_state_nxt  = IDLE;
            w_req_nxt    = 1'b0;
            w_credit_nxt = '0;
            w_error_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_ok) begin
                        w_state_nxt = REQ;
                        w_req_nxt   = 1'b1;
                    end
                end
                REQ: begin
                    if (bus.fct_ack) begin
                        w_state_nxt = GAP;
                        w_req_nxt   = 1'b0;
                    end
                end
                GAP: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_req_nxt   = 1'b0;
                end
            endcase

            // A char landing with the FCT at zero credit arrived before the grant: error, full 8 granted.
            if (w_ack_hit && bus.nchar_rx) begin
                if (r_credit == '0) begin
                    w_credit_nxt = AWIDTH'(FCT_CREDIT);
                    w_error_nxt  = 1'b1;
                end else begin
                    w_credit_nxt = r_credit + AWIDTH'(FCT_CREDIT - 1);
                end
            end else if (w_ack_hit) begin
                w_credit_nxt = r_credit + AWIDTH'(FCT_CREDIT);
            end else if (bus.nchar_rx) begin
                if (r_credit == '0) begin
                    w_error_nxt = 1'b1;
                end else begin
                    w_credit_nxt = r_credit - AWIDTH'(1);
                end
            end
        end
    end

    assign bus.fct_req      = r_fct_req;
    assign bus.credit_out   = r_credit;
    assign bus.credit_error = r_error;
    assign bus.state        = r_state;

endmodule

// File: tb/tb_rx_fct_credit_ctrl.sv
// Bench for rx_fct_credit_ctrl: directed flow-control scenarios followed by a randomized
// run, every cycle compared against a credit/request model kept in plain integers.
module tb_rx_fct_credit_ctrl;

    import rx_fct_credit_ctrl_pkg::*;

    localparam int AW   = 6;
    localparam int LAST = 63;
    localparam int CMAX = 56;
    localparam int FCT  = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    rx_fct_credit_ctrl_if #(.AWIDTH(AW)) bus ();

    rx_fct_credit_ctrl #(
        .AWIDTH    (AW),
        .FIFO_LAST (LAST),
        .CREDIT_MAX(CMAX),
        .FCT_CREDIT(FCT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: peer credit, sticky error, request outstanding, one-cycle cooldown.
    int m_credit = 0;
    int m_err    = 0;
    int m_pend   = 0;
    int m_cool   = 0;
    int m_wait   = 0;
    int ack_dly  = -1;
    int n_rise   = 0;
    bit prev_req = 1'b0;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input bit en, input int fifo, input bit nc, input bit ak_in);
        bit ak;
        int c, room;
        int n_credit, n_err, n_pend, n_cool, exp_state;
        ak = ak_in;
        if (ack_dly >= 0 && m_pend != 0) begin
            m_wait++;
            if (m_wait >= ack_dly) ak = 1'b1;
        end

        @(negedge clock);
        bus.link_enable = en;
        bus.fifo_count  = AW'(fifo);
        bus.nchar_rx    = nc;
        bus.fct_ack     = ak;

        c        = m_credit;
        n_credit = c;
        n_err    = m_err;
        n_pend   = m_pend;
        n_cool   = m_cool;
        if (!en) begin
            n_credit = 0; n_err = 0; n_pend = 0; n_cool = 0;
        end else begin
            room = (CMAX < LAST - fifo) ? CMAX : LAST - fifo;
            if (m_pend != 0 && ak && nc) begin
                if (c == 0) begin n_credit = FCT; n_err = 1; end
                else n_credit = c + FCT - 1;
            end else if (m_pend != 0 && ak) begin
                n_credit = c + FCT;
            end else if (nc) begin
                if (c == 0) n_err = 1;
                else n_credit = c - 1;
            end
            if (m_pend != 0) begin
                if (ak) begin n_pend = 0; n_cool = 1; end
            end else if (m_cool != 0) begin
                n_cool = 0;
            end else if (c + FCT <= room) begin
                n_pend = 1;
            end
        end

        @(posedge clock);
        #1;
        m_credit = n_credit;
        m_err    = n_err;
        m_pend   = n_pend;
        m_cool   = n_cool;
        if (m_pend == 0) m_wait = 0;
        exp_state = (m_pend != 0) ? int'(REQ) : ((m_cool != 0) ? int'(GAP) : int'(IDLE));

        chk("fct_req", int'(bus.fct_req), m_pend);
        chk("credit_out", int'(bus.credit_out), m_credit);
        chk("credit_error", int'(bus.credit_error), m_err);
        chk("state", int'(bus.state), exp_state);
        chk("credit_le_max", int'(bus.credit_out <= AW'(CMAX)), 1);

        if (bus.fct_req && !prev_req) n_rise++;
        prev_req = bus.fct_req;
    endtask

    task automatic wait_req(input int fifo, input int max_cycles);
        int k = 0;
        while (m_pend == 0 && k < max_cycles) begin
            step(1'b1, fifo, 1'b0, 1'b0);
            k++;
        end
        chk("wait_req", int'(bus.fct_req), 1);
    endtask

    initial begin
        bus.link_enable = 1'b0;
        bus.fifo_count  = '0;
        bus.nchar_rx    = 1'b0;
        bus.fct_ack     = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_fct_req", int'(bus.fct_req), 0);
        chk("rst_credit", int'(bus.credit_out), 0);
        chk("rst_error", int'(bus.credit_error), 0);
        chk("rst_state", int'(bus.state), int'(IDLE));
        @(negedge clock);
        reset = 1'b1;

        // Empty FIFO, each request acked 2 cycles later: 7 grants up to the credit ceiling.
        ack_dly = 2;
        n_rise  = 0;
        repeat (40) step(1'b1, 0, 1'b0, 1'b0);
        chk("fill_fct_count", n_rise, 7);
        chk("fill_credit", int'(bus.credit_out), 56);
        chk("fill_req_idle", int'(bus.fct_req), 0);

        // 10 N-chars consume credit; a request appears once credit <= 48.
        ack_dly = -1;
        repeat (10) step(1'b1, 0, 1'b1, 1'b0);
        chk("drain_credit", int'(bus.credit_out), 46);
        chk("drain_req", int'(bus.fct_req), 1);
        ack_dly = 1;
        repeat (4) step(1'b1, 0, 1'b0, 1'b0);
        chk("drain_refill", int'(bus.credit_out), 54);
        chk("drain_no_more", int'(bus.fct_req), 0);

        // Nearly full FIFO limits grants by free space.
        step(1'b0, 0, 1'b0, 1'b0);
        n_rise  = 0;
        ack_dly = 2;
        repeat (12) step(1'b1, 50, 1'b0, 1'b0);
        chk("room_one_fct", n_rise, 1);
        chk("room_credit", int'(bus.credit_out), 8);
        repeat (12) step(1'b1, 48, 1'b0, 1'b0);
        chk("room_48_no_fct", n_rise, 1);
        repeat (12) step(1'b1, 47, 1'b0, 1'b0);
        chk("room_47_fct", n_rise, 2);
        chk("room_47_credit", int'(bus.credit_out), 16);

        // N-char at zero credit: sticky error until link drops.
        ack_dly = -1;
        step(1'b0, 63, 1'b0, 1'b0);
        step(1'b1, 63, 1'b1, 1'b0);
        chk("err_set", int'(bus.credit_error), 1);
        chk("err_credit_zero", int'(bus.credit_out), 0);
        repeat (3) step(1'b1, 63, 1'b0, 1'b0);
        chk("err_sticky", int'(bus.credit_error), 1);
        step(1'b0, 63, 1'b0, 1'b0);
        chk("err_cleared", int'(bus.credit_error), 0);

        // Ack and N-char together with credit 16, then with credit 0.
        wait_req(0, 5);
        step(1'b1, 0, 1'b0, 1'b1);
        wait_req(0, 5);
        step(1'b1, 0, 1'b0, 1'b1);
        wait_req(0, 5);
        chk("both_pre_credit", int'(bus.credit_out), 16);
        step(1'b1, 0, 1'b1, 1'b1);
        chk("both_credit_23", int'(bus.credit_out), 23);
        chk("both_no_error", int'(bus.credit_error), 0);
        step(1'b0, 0, 1'b0, 1'b0);
        wait_req(0, 5);
        step(1'b1, 0, 1'b1, 1'b1);
        chk("both_zero_credit", int'(bus.credit_out), 8);
        chk("both_zero_error", int'(bus.credit_error), 1);

        // Link drop during a request, ack in the same cycle, adds nothing.
        wait_req(0, 5);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("drop_req", int'(bus.fct_req), 0);
        chk("drop_credit", int'(bus.credit_out), 0);
        chk("drop_state", int'(bus.state), int'(IDLE));

        // Randomized traffic against the model.
        begin
            int fifo = 0;
            for (int i = 0; i < 3000; i++) begin
                bit en, nc, ak;
                if ((i % 8) == 0) fifo = $urandom_range(0, 63);
                en = ($urandom_range(0, 99) >= 2);
                nc = ($urandom_range(0, 99) < 30);
                ak = ($urandom_range(0, 99) < 35);
                step(en, fifo, nc, ak);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
